// File: rtl/ordered_set_generator_if.sv
// Request and PIPE-TX signal bundle for the ordered-set generator.
// master = requester / PIPE consumer side, slave = generator.
interface ordered_set_generator_if #(
  parameter int DATA_WIDTH = 32
);
  logic [2:0]              curr_data_rate_i;
  logic [5:0]              pipe_width_i;
  logic [2:0]              os_type_i;
  logic                    os_valid_i;
  logic                    os_ready_o;
  logic [7:0]              link_num_i;
  logic [7:0]              lane_num_i;
  logic [7:0]              nfts_i;
  logic [7:0]              rate_id_i;
  logic [7:0]              training_ctrl_i;
  logic [7:0]              symbol6_i;
  logic                    tx_ready_i;
  logic [DATA_WIDTH-1:0]   data_out_o;
  logic [DATA_WIDTH/8-1:0] data_k_o;
  logic                    data_valid_o;
  logic                    data_start_o;
  logic [1:0]              sync_header_o;
  logic                    os_done_o;
  logic                    os_err_o;

  modport master (
    output curr_data_rate_i, pipe_width_i, os_type_i, os_valid_i,
           link_num_i, lane_num_i, nfts_i, rate_id_i, training_ctrl_i,
           symbol6_i, tx_ready_i,
    input  os_ready_o, data_out_o, data_k_o, data_valid_o, data_start_o,
           sync_header_o, os_done_o, os_err_o
  );

  modport slave (
    input  curr_data_rate_i, pipe_width_i, os_type_i, os_valid_i,
           link_num_i, lane_num_i, nfts_i, rate_id_i, training_ctrl_i,
           symbol6_i, tx_ready_i,
    output os_ready_o, data_out_o, data_k_o, data_valid_o, data_start_o,
           sync_header_o, os_done_o, os_err_o
  );
endinterface

// File: rtl/ordered_set_generator.sv
// Builds a TS1/TS2/EIEOS/EIOS/SKP ordered set into a 16-byte buffer on request
// acceptance and streams it to the PIPE TX side in 2- or 4-byte beats.
module ordered_set_generator #(
  parameter int DATA_WIDTH = 32
) (
  input logic clk_i,
  input logic rst_ni,
  ordered_set_generator_if.slave os
);
  // Rate encoding: 0 gen1, 1 gen2, 2 gen3, 3 gen4, 4 gen5
  localparam logic [2:0] RATE_GEN3 = 3'd2;
  localparam logic [2:0] OS_TS1    = 3'd0;
  localparam logic [2:0] OS_TS2    = 3'd1;
  localparam logic [2:0] OS_EIEOS  = 3'd2;
  localparam logic [2:0] OS_EIOS   = 3'd3;
  localparam logic [2:0] OS_SKP    = 3'd4;

  typedef enum logic {ST_IDLE, ST_SEND} state_t;
  state_t state, state_next;

  logic         accept, legal, take, last, mode_new, wide_new, len4_new;
  logic [143:0] set_new;
  logic [35:0]  first_beat, next_beat;
  logic [127:0] set_p1;
  logic [15:0]  setk_p1;
  logic         wide_p1;
  logic [3:0]   last_idx_p1, beat_cnt_p1;
  logic [31:0]  data_p1;
  logic [3:0]   k_p1;
  logic [1:0]   sync_p1;
  logic         vld_p1, start_p1, done_p1, err_p1;

  // Returns {k[15:0], bytes[127:0]} with symbol n at byte lane n.
  function automatic logic [143:0] build_set(
    input logic m130, input logic [2:0] typ,
    input logic [7:0] link, input logic [7:0] lane, input logic [7:0] nfts,
    input logic [7:0] rid, input logic [7:0] tctl, input logic [7:0] s6);
    logic [127:0] d;
    logic [15:0]  k;
    logic [7:0]   fill;
    d    = '0;
    k    = '0;
    fill = (typ == OS_TS2) ? 8'h45 : 8'h4A;
    case (typ)
      OS_TS1, OS_TS2: begin
        d[7:0]   = m130 ? ((typ == OS_TS2) ? 8'h2D : 8'h1E) : 8'hBC;
        k[0]     = !m130;
        d[15:8]  = link;
        d[23:16] = lane;
        d[31:24] = nfts;
        d[39:32] = rid;
        d[47:40] = tctl;
        d[55:48] = s6;
        for (int i = 7; i < 16; i++) d[8*i+:8] = fill;
      end
      OS_EIEOS: begin
        if (m130) begin
          for (int i = 0; i < 16; i++) d[8*i+:8] = i[0] ? 8'hFF : 8'h00;
        end else begin
          d[7:0] = 8'hBC;
          for (int i = 1; i < 15; i++) d[8*i+:8] = 8'hFC;
          d[127:120] = 8'h4A;
          k = 16'h7FFF;
        end
      end
      OS_EIOS: begin
        if (m130) d = {16{8'h66}};
        else begin
          d[31:0] = 32'h7C7C7CBC;
          k       = 16'h000F;
        end
      end
      OS_SKP: begin
        if (m130) d = {24'h000000, 8'hE1, {12{8'hAA}}};
        else begin
          d[31:0] = 32'h1C1C1CBC;
          k       = 16'h000F;
        end
      end
      default: ;
    endcase
    return {k, d};
  endfunction

  // Earliest symbol of the beat lands in the most significant active byte.
  function automatic logic [35:0] beat_word(
    input logic [127:0] s, input logic [15:0] k,
    input logic [3:0] idx, input logic wide);
    logic [31:0] d;
    logic [3:0]  kf;
    logic [3:0]  b;
    d  = '0;
    kf = '0;
    b  = '0;
    if (wide) begin
      for (int n = 0; n < 4; n++) begin
        b              = {idx[1:0], 2'b00} + 4'(n);
        d[8*(3-n)+:8]  = s[8*b+:8];
        kf[3-n]        = k[b];
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        b              = {idx[2:0], 1'b0} + 4'(n);
        d[8*(1-n)+:8]  = s[8*b+:8];
        kf[1-n]        = k[b];
      end
    end
    return {kf, d};
  endfunction

  always_comb begin
    legal      = os.os_type_i <= OS_SKP;
    accept     = os.os_valid_i && (state == ST_IDLE);
    take       = vld_p1 && os.tx_ready_i;
    last       = beat_cnt_p1 == last_idx_p1;
    mode_new   = os.curr_data_rate_i >= RATE_GEN3;
    wide_new   = os.pipe_width_i == 6'd32;
    len4_new   = !mode_new && ((os.os_type_i == OS_EIOS) || (os.os_type_i == OS_SKP));
    set_new    = build_set(mode_new, os.os_type_i, os.link_num_i, os.lane_num_i,
                           os.nfts_i, os.rate_id_i, os.training_ctrl_i, os.symbol6_i);
    first_beat = beat_word(set_new[127:0], set_new[143:128], 4'd0, wide_new);
    next_beat  = beat_word(set_p1, setk_p1, beat_cnt_p1 + 4'd1, wide_p1);
    state_next = state;
    case (state)
      ST_IDLE: if (accept && legal) state_next = ST_SEND;
      ST_SEND: if (take && last)    state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Stage p1: set buffer captured at acceptance; later input changes are ignored.
  always_ff @(posedge clk_i) begin
    if (accept && legal) begin
      set_p1  <= set_new[127:0];
      setk_p1 <= set_new[143:128];
      wide_p1 <= wide_new;
    end
  end

  // Stage p1: registered beat presented to PIPE, held while tx_ready_i is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1      <= 1'b0;
      start_p1    <= 1'b0;
      sync_p1     <= 2'b00;
      data_p1     <= '0;
      k_p1        <= '0;
      done_p1     <= 1'b0;
      err_p1      <= 1'b0;
      beat_cnt_p1 <= '0;
      last_idx_p1 <= '0;
    end else begin
      done_p1 <= 1'b0;
      err_p1  <= 1'b0;
      if (accept) begin
        if (legal) begin
          vld_p1            <= 1'b1;
          start_p1          <= 1'b1;
          sync_p1           <= mode_new ? 2'b10 : 2'b00;
          {k_p1, data_p1}   <= first_beat;
          beat_cnt_p1       <= '0;
          last_idx_p1       <= len4_new ? (wide_new ? 4'd0 : 4'd1) : (wide_new ? 4'd3 : 4'd7);
        end else begin
          err_p1 <= 1'b1;
        end
      end else if (take) begin
        start_p1 <= 1'b0;
        sync_p1  <= 2'b00;
        if (last) begin
          vld_p1      <= 1'b0;
          data_p1     <= '0;
          k_p1        <= '0;
          done_p1     <= 1'b1;
          beat_cnt_p1 <= '0;
        end else begin
          {k_p1, data_p1} <= next_beat;
          beat_cnt_p1     <= beat_cnt_p1 + 4'd1;
        end
      end
    end
  end

  assign os.os_ready_o    = (state == ST_IDLE);
  assign os.data_out_o    = data_p1;
  assign os.data_k_o      = k_p1;
  assign os.data_valid_o  = vld_p1;
  assign os.data_start_o  = start_p1;
  assign os.sync_header_o = sync_p1;
  assign os.os_done_o     = done_p1;
  assign os.os_err_o      = err_p1;
endmodule
